// File: rtl/data_sync_pkg.sv
// Shared types and constants for the data_sync req/ack crossing.
// No ports; imported by the interface, the synchronizer and the responder.
package data_sync_pkg;

    // FSM encoding width and states
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Default geometry
    localparam int unsigned DEF_BUS_WIDTH  = 8;
    localparam int unsigned DEF_NUM_STAGES = 2;

    // Shallowest synchronizer accepted at elaboration
    localparam int unsigned MIN_STAGES     = 2;

endpackage

// File: rtl/data_sync_rx_if.sv
// Signal bundle between the source/consumer side and the data_sync_rx responder.
//   unsync_req  source request level (async to dest_clk)
//   unsync_bus  quasi-static source word
//   ack         acknowledge level back to the source
//   dest_ready  consumer accepts sync_bus
//   sync_bus    captured word
//   sync_valid  sync_bus holds an unaccepted word
//   proto_err   one-cycle protocol violation pulse
// master: environment side (source + consumer); slave: the responder.
interface data_sync_rx_if
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH
);

    logic                 unsync_req;
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 ack;
    logic                 dest_ready;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 sync_valid;
    logic                 proto_err;

    modport master (
        output unsync_req,
        output unsync_bus,
        output dest_ready,
        input  ack,
        input  sync_bus,
        input  sync_valid,
        input  proto_err
    );

    modport slave (
        input  unsync_req,
        input  unsync_bus,
        input  dest_ready,
        output ack,
        output sync_bus,
        output sync_valid,
        output proto_err
    );

endinterface

// File: rtl/data_sync_rx_sync_chain.sv
// sync_chain: NUM_STAGES-deep single-bit synchronizer, async active-low reset to 0.
// Ports:
//   dest_clk  destination clock
//   dest_rst  asynchronous active-low reset
//   d         asynchronous input level
//   q         synchronized level (last stage)
module sync_chain
    import data_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic dest_clk,
    input  logic dest_rst,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] stage_q;

    // Shift chain; stage 0 is the only flop that sees the raw input
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[NUM_STAGES-2:0], d};
        end
    end

    assign q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_rx.sv
// data_sync_rx: destination-side responder of a four-phase req/ack crossing.
// Synchronizes the request, captures the quasi-static source word once the
// request is seen, offers it to a local consumer via valid/ready and returns
// a registered acknowledge level to the source domain.
// Ports:
//   dest_clk  destination clock (rising edge)
//   dest_rst  asynchronous active-low reset
//   bus_if    slave side of data_sync_rx_if (req/bus/ack + valid/ready + proto_err)
module data_sync_rx
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic                 dest_clk,
    input  logic                 dest_rst,
    data_sync_rx_if.slave        bus_if
);

    // Reject synchronizers too shallow to settle metastability
    generate
        if (NUM_STAGES < MIN_STAGES) begin : g_bad_stages
            $error("data_sync_rx: NUM_STAGES must be at least %0d", MIN_STAGES);
        end
    endgenerate

    logic                 req_s;
    state_e               state_q;
    logic [BUS_WIDTH-1:0] sync_bus_q;
    logic                 sync_valid_q;
    logic                 ack_q;
    logic                 proto_err_q;
    logic                 err_seen_q;

    // Request synchronizer; instance name is the CDC constraint anchor
    sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .dest_clk (dest_clk),
        .dest_rst (dest_rst),
        .d        (bus_if.unsync_req),
        .q        (req_s)
    );

    // Handshake FSM with capture and output registers.
    // err_seen_q limits proto_err to one pulse per stay in HOLD.
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            state_q      <= ST_IDLE;
            sync_bus_q   <= '0;
            sync_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            proto_err_q  <= 1'b0;
            err_seen_q   <= 1'b0;
        end else begin
            proto_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ack_q        <= 1'b0;
                    sync_valid_q <= 1'b0;
                    err_seen_q   <= 1'b0;
                    if (req_s) begin
                        // Source holds the bus stable from req rise until ack
                        sync_bus_q   <= bus_if.unsync_bus;
                        sync_valid_q <= 1'b1;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!req_s && !err_seen_q) begin
                        proto_err_q <= 1'b1;
                        err_seen_q  <= 1'b1;
                    end
                    if (sync_valid_q && bus_if.dest_ready) begin
                        sync_valid_q <= 1'b0;
                        ack_q        <= 1'b1;
                        state_q      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    ack_q        <= 1'b0;
                    sync_valid_q <= 1'b0;
                    err_seen_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.sync_bus   = sync_bus_q;
    assign bus_if.sync_valid = sync_valid_q;
    assign bus_if.ack        = ack_q;
    assign bus_if.proto_err  = proto_err_q;

endmodule

// File: tb/tb_data_sync_rx.sv
// Self-checking bench for data_sync_rx: three instances (NUM_STAGES 2/3/4)
// share one source/consumer stimulus; the depth-2 instance drives the
// handshake sequencing and the scoreboard.
module tb_data_sync_rx;
    import data_sync_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [7:0] bus;
    logic       ready;

    data_sync_rx_if #(.BUS_WIDTH(8)) if_s2 ();
    data_sync_rx_if #(.BUS_WIDTH(8)) if_s3 ();
    data_sync_rx_if #(.BUS_WIDTH(8)) if_s4 ();

    assign if_s2.unsync_req = req;
    assign if_s2.unsync_bus = bus;
    assign if_s2.dest_ready = ready;
    assign if_s3.unsync_req = req;
    assign if_s3.unsync_bus = bus;
    assign if_s3.dest_ready = ready;
    assign if_s4.unsync_req = req;
    assign if_s4.unsync_bus = bus;
    assign if_s4.dest_ready = ready;

    data_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(2)) u_dut2 (
        .dest_clk (clk), .dest_rst (rst_n), .bus_if (if_s2.slave));
    data_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(3)) u_dut3 (
        .dest_clk (clk), .dest_rst (rst_n), .bus_if (if_s3.slave));
    data_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(4)) u_dut4 (
        .dest_clk (clk), .dest_rst (rst_n), .bus_if (if_s4.slave));

    logic [7:0] o_bus   [3];
    logic       o_valid [3];
    logic       o_ack   [3];
    logic       o_err   [3];

    assign o_bus[0]   = if_s2.sync_bus;
    assign o_valid[0] = if_s2.sync_valid;
    assign o_ack[0]   = if_s2.ack;
    assign o_err[0]   = if_s2.proto_err;
    assign o_bus[1]   = if_s3.sync_bus;
    assign o_valid[1] = if_s3.sync_valid;
    assign o_ack[1]   = if_s3.ack;
    assign o_err[1]   = if_s3.proto_err;
    assign o_bus[2]   = if_s4.sync_bus;
    assign o_valid[2] = if_s4.sync_valid;
    assign o_ack[2]   = if_s4.ack;
    assign o_err[2]   = if_s4.proto_err;

    localparam int NS [3] = '{2, 3, 4};

    typedef struct {
        logic [7:0] data;
        int         stall;
        bit         early;
        int         exp_err;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] sb_q [$];
    int         n_checks;
    int         n_fail;
    int         n_recv;
    int         err_pulses;
    bit         mon_skip;
    logic [7:0] prev_bus   [3];
    logic       prev_valid [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: sync_bus stability, proto_err width, scoreboard pop
    task automatic monitor();
        if (o_err[0]) err_pulses++;
        if (!mon_skip) begin
            for (int i = 0; i < 3; i++) begin
                if (o_bus[i] !== prev_bus[i])
                    check($sformatf("bus_change_only_on_capture_ns%0d", NS[i]),
                          32'(o_valid[i] & ~prev_valid[i]), 32'd1);
            end
            if (prev_valid[0] && !o_valid[0] && o_ack[0]) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(o_bus[0]), 32'hFFFF_FFFF);
                end else begin
                    check("sb_word", 32'(o_bus[0]), 32'(sb_q.pop_front()));
                    n_recv++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            prev_bus[i]   = o_bus[i];
            prev_valid[i] = o_valid[i];
        end
        mon_skip = !rst_n;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    // One four-phase transfer against the depth-2 instance
    task automatic xfer(input vec_t v);
        int lat;
        bit seen;
        err_pulses = 0;
        bus   = v.data;
        req   = 1'b1;
        ready = (v.stall == 0);
        sb_q.push_back(v.data);
        lat = 0; seen = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            step();
            if (o_valid[0]) begin seen = 1; lat = k; end
        end
        check("valid_latency", 32'(lat), 32'd3);
        check("capture_word", 32'(o_bus[0]), 32'(v.data));
        if (v.early) req = 1'b0;
        for (int k = 0; k < v.stall; k++) begin
            step();
            check("stall_valid", 32'(o_valid[0]), 32'd1);
            check("stall_ack",   32'(o_ack[0]),   32'd0);
            check("stall_bus",   32'(o_bus[0]),   32'(v.data));
        end
        ready = 1'b1;
        step();
        check("ack_rise",   32'(o_ack[0]),   32'd1);
        check("valid_fall", 32'(o_valid[0]), 32'd0);
        if (!v.early) req = 1'b0;
        lat = 0; seen = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            step();
            if (!o_ack[0]) begin seen = 1; lat = k; end
        end
        if (v.early)
            check("ack_fall_within_bound", 32'(lat >= 1 && lat <= 3), 32'd1);
        else
            check("ack_fall_latency", 32'(lat), 32'd3);
        check("proto_err_cycles", 32'(err_pulses), 32'(v.exp_err));
        ready = 1'b0;
    endtask

    // Random-phase request against all three depths, dest_ready held high
    task automatic sweep_trial();
        int ph;
        int late;
        logic [7:0] d;
        bit vseen [3];
        bit aseen [3];
        bit fseen [3];
        int vlat [3];
        int alat [3];
        int flat [3];
        d  = 8'($urandom_range(0, 255));
        ph = $urandom_range(1, 8);
        if (ph >= 5) ph++;
        late = (ph > 5) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            vseen[i] = 0; aseen[i] = 0; fseen[i] = 0;
            vlat[i] = 0; alat[i] = 0; flat[i] = 0;
        end
        bus = d;
        sb_q.push_back(d);
        #(ph);
        req = 1'b1;
        for (int k = 1; k <= 20 && !(aseen[0] && aseen[1] && aseen[2]); k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (!vseen[i] && o_valid[i]) begin
                    vseen[i] = 1; vlat[i] = k;
                    check($sformatf("sweep_word_ns%0d", NS[i]), 32'(o_bus[i]), 32'(d));
                end
                if (!aseen[i] && o_ack[i]) begin aseen[i] = 1; alat[i] = k; end
            end
        end
        req = 1'b0;
        for (int k = 1; k <= 20 && !(fseen[0] && fseen[1] && fseen[2]); k++) begin
            step();
            for (int i = 0; i < 3; i++)
                if (!fseen[i] && !o_ack[i]) begin fseen[i] = 1; flat[i] = k; end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sweep_valid_lat_ns%0d", NS[i]), 32'(vlat[i]), 32'(NS[i] + 1 + late));
            check($sformatf("sweep_ack_lat_ns%0d", NS[i]),   32'(alat[i]), 32'(NS[i] + 2 + late));
            check($sformatf("sweep_ack_fall_ns%0d", NS[i]),  32'(flat[i]), 32'(NS[i] + 1));
        end
    endtask

    initial begin
        int lat;
        bit seen;
        n_checks = 0; n_fail = 0; n_recv = 0; err_pulses = 0;
        mon_skip = 1'b1;
        for (int i = 0; i < 3; i++) begin prev_bus[i] = '0; prev_valid[i] = 1'b0; end
        vecs[0] = '{data: 8'hA5, stall: 0,  early: 1'b0, exp_err: 0};
        vecs[1] = '{data: 8'h3C, stall: 10, early: 1'b0, exp_err: 0};
        vecs[2] = '{data: 8'h01, stall: 0,  early: 1'b0, exp_err: 0};
        vecs[3] = '{data: 8'h02, stall: 0,  early: 1'b0, exp_err: 0};
        vecs[4] = '{data: 8'hFF, stall: 0,  early: 1'b0, exp_err: 0};
        vecs[5] = '{data: 8'h5A, stall: 6,  early: 1'b1, exp_err: 1};
        vecs[6] = '{data: 8'hC3, stall: 2,  early: 1'b0, exp_err: 0};

        rst_n = 1'b0; req = 1'b0; bus = 8'h00; ready = 1'b0;
        #1;
        check("reset_valid", 32'(o_valid[0]), 32'd0);
        check("reset_ack",   32'(o_ack[0]),   32'd0);
        check("reset_bus",   32'(o_bus[0]),   32'd0);
        check("reset_err",   32'(o_err[0]),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) xfer(vecs[i]);
        check("words_received_table", 32'(n_recv), 32'd7);

        // Reset while a word is held in HOLD
        bus = 8'h77; req = 1'b1; ready = 1'b0;
        seen = 0; lat = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            step();
            if (o_valid[0]) begin seen = 1; lat = k; end
        end
        check("midreset_valid_before", 32'(lat), 32'd3);
        #2;
        rst_n = 1'b0;
        mon_skip = 1'b1;
        #1;
        check("midreset_valid", 32'(o_valid[0]), 32'd0);
        check("midreset_ack",   32'(o_ack[0]),   32'd0);
        check("midreset_bus",   32'(o_bus[0]),   32'd0);
        check("midreset_err",   32'(o_err[0]),   32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("idle_after_reset",
                  32'({o_valid[0], o_ack[0], o_err[0], o_bus[0],
                       o_valid[2], o_ack[2], o_bus[2]}), 32'd0);
        end

        ready = 1'b1;
        for (int t = 0; t < 6; t++) sweep_trial();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) step();

        check("words_received_total", 32'(n_recv), 32'd13);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
